// File: rtl/time_display_driver.sv
// Converts binary h/m/s from time_counter to BCD with a shift-add-3 pass on change,
// commits it atomically, and scans six multiplexed seven-segment digits.
module time_display_driver #(
   parameter int SCAN_DIV = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [7:0]  seconds,
   input  logic [7:0]  minutes,
   input  logic [7:0]  hours,
   input  logic        blank,
   output logic [6:0]  seg,
   output logic [5:0]  an,
   output logic        dp,
   output logic [23:0] bcd_out,
   output logic        busy
);

   typedef enum logic [1:0] {IDLE, CONV, COMMIT} state_t;

   state_t      state, state_nx;
   logic [7:0]  sh_s, sh_m, sh_h;
   logic [7:0]  sr_s, sr_m, sr_h;
   logic [7:0]  acc_s, acc_m, acc_h;
   logic [7:0]  adj_s, adj_m, adj_h;
   logic [2:0]  bit_cnt;
   logic        changed;
   logic [15:0] div_cnt;
   logic [2:0]  idx;
   logic [3:0]  digit;

   function automatic logic [7:0] add3(input logic [7:0] a);
      logic [7:0] r;
      r = a;
      if (r[3:0] >= 4'd5) r[3:0] = r[3:0] + 4'd3;
      if (r[7:4] >= 4'd5) r[7:4] = r[7:4] + 4'd3;
      return r;
   endfunction

   // Out-of-range fields show as two dashes; the hundreds digit is never tracked.
   function automatic logic [7:0] fix(input logic [7:0] v, input logic [7:0] a);
      return (v > 8'd99) ? 8'hFF : a;
   endfunction

   function automatic logic [6:0] seg_code(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'd0:    s = 7'h3F;
         4'd1:    s = 7'h06;
         4'd2:    s = 7'h5B;
         4'd3:    s = 7'h4F;
         4'd4:    s = 7'h66;
         4'd5:    s = 7'h6D;
         4'd6:    s = 7'h7D;
         4'd7:    s = 7'h07;
         4'd8:    s = 7'h7F;
         4'd9:    s = 7'h6F;
         4'hF:    s = 7'h40;
         default: s = 7'h00;
      endcase
      return s;
   endfunction

   assign changed = {hours, minutes, seconds} != {sh_h, sh_m, sh_s};
   assign adj_s   = add3(acc_s);
   assign adj_m   = add3(acc_m);
   assign adj_h   = add3(acc_h);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (changed) state_nx = CONV;
         CONV:    if (bit_cnt == 3'd7) state_nx = COMMIT;
         COMMIT:  state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sh_s    <= '0;
         sh_m    <= '0;
         sh_h    <= '0;
         sr_s    <= '0;
         sr_m    <= '0;
         sr_h    <= '0;
         acc_s   <= '0;
         acc_m   <= '0;
         acc_h   <= '0;
         bit_cnt <= '0;
         bcd_out <= '0;
         busy    <= 1'b0;
      end else begin
         case (state)
            IDLE: if (changed) begin
               sh_s    <= seconds;
               sh_m    <= minutes;
               sh_h    <= hours;
               sr_s    <= seconds;
               sr_m    <= minutes;
               sr_h    <= hours;
               acc_s   <= '0;
               acc_m   <= '0;
               acc_h   <= '0;
               bit_cnt <= '0;
               busy    <= 1'b1;
            end
            CONV: begin
               acc_s   <= {adj_s[6:0], sr_s[7]};
               acc_m   <= {adj_m[6:0], sr_m[7]};
               acc_h   <= {adj_h[6:0], sr_h[7]};
               sr_s    <= {sr_s[6:0], 1'b0};
               sr_m    <= {sr_m[6:0], 1'b0};
               sr_h    <= {sr_h[6:0], 1'b0};
               bit_cnt <= bit_cnt + 3'd1;
            end
            COMMIT: begin
               bcd_out <= {fix(sh_h, acc_h), fix(sh_m, acc_m), fix(sh_s, acc_s)};
               busy    <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         div_cnt <= '0;
         idx     <= '0;
      end else if (div_cnt == 16'(SCAN_DIV - 1)) begin
         div_cnt <= '0;
         idx     <= (idx == 3'd5) ? 3'd0 : idx + 3'd1;
      end else begin
         div_cnt <= div_cnt + 16'd1;
      end
   end

   always_comb begin
      digit = 4'd0;
      case (idx)
         3'd0:    digit = bcd_out[3:0];
         3'd1:    digit = bcd_out[7:4];
         3'd2:    digit = bcd_out[11:8];
         3'd3:    digit = bcd_out[15:12];
         3'd4:    digit = bcd_out[19:16];
         3'd5:    digit = bcd_out[23:20];
         default: digit = 4'd0;
      endcase
   end

   // Display outputs lag the scan index by one cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         seg <= 7'h3F;
         an  <= 6'b000001;
         dp  <= 1'b0;
      end else begin
         seg <= seg_code(digit);
         an  <= blank ? 6'b000000 : (6'b000001 << idx);
         dp  <= (idx == 3'd2) || (idx == 3'd4);
      end
   end

endmodule

// File: tb/tb_time_display_driver.sv
// Directed plus randomized checks of time_display_driver against an arithmetic model
// of the BCD result and a cycle-count model of the digit scan.
module tb_time_display_driver;

   localparam int DIV = 1;

   logic        clk = 1'b0;
   logic        reset;
   logic [7:0]  seconds, minutes, hours;
   logic        blank;
   logic [6:0]  seg;
   logic [5:0]  an;
   logic        dp;
   logic [23:0] bcd_out;
   logic        busy;

   int n_chk  = 0;
   int n_fail = 0;
   int cyc;

   time_display_driver #(.SCAN_DIV(DIV)) dut (
      .clk(clk), .reset(reset), .seconds(seconds), .minutes(minutes), .hours(hours),
      .blank(blank), .seg(seg), .an(an), .dp(dp), .bcd_out(bcd_out), .busy(busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk or posedge reset) begin
      if (reset) cyc <= 0;
      else       cyc <= cyc + 1;
   end

   function automatic logic [7:0] fld(input int v);
      if (v > 99) return 8'hFF;
      return {4'(v / 10), 4'(v % 10)};
   endfunction

   function automatic logic [23:0] model_bcd(input int h, input int m, input int s);
      return {fld(h), fld(m), fld(s)};
   endfunction

   function automatic logic [6:0] model_seg(input logic [3:0] d);
      logic [6:0] tab [16];
      tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
              7'h7F, 7'h6F, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h40};
      return tab[d];
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Digit shown after k edges since reset release: the index held before edge k.
   task automatic chk_scan(input logic [23:0] exp_bcd, input logic blanked);
      int k;
      int i;
      logic [3:0] d;
      k = cyc;
      i = (k == 0) ? 0 : ((k - 1) / DIV) % 6;
      d = exp_bcd[i*4 +: 4];
      chk("an",  32'(an),  blanked ? 32'd0 : 32'(1 << i));
      chk("seg", 32'(seg), 32'(model_seg(d)));
      chk("dp",  32'(dp),  32'((i == 2) || (i == 4)));
   endtask

   task automatic set_time(input int h, input int m, input int s);
      hours = 8'(h); minutes = 8'(m); seconds = 8'(s);
   endtask

   initial begin
      int h, m, s, ph, pm, ps;
      logic [23:0] e;

      reset = 1'b1; blank = 1'b0;
      set_time(0, 0, 0);
      #2;
      chk("rst_bcd", 32'(bcd_out), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_an", 32'(an), 32'h01);
      chk("rst_seg", 32'(seg), 32'h3F);
      chk("rst_dp", 32'(dp), 0);
      #6 reset = 1'b0;
      step();

      // 12:34:56 with exact latency
      set_time(12, 34, 56);
      step();
      chk("lat_busy_n", 32'(busy), 1);
      chk("lat_bcd_n", 32'(bcd_out), 0);
      for (int i = 1; i <= 8; i++) begin
         step();
         chk("lat_bcd_mid", 32'(bcd_out), 0);
         chk("lat_busy_mid", 32'(busy), 1);
      end
      step();
      chk("lat_bcd_done", 32'(bcd_out), 32'h123456);
      chk("lat_busy_done", 32'(busy), 0);
      for (int i = 0; i < 7; i++) begin step(); chk_scan(24'h123456, 1'b0); end

      // blank suppresses an only
      blank = 1'b1;
      for (int i = 0; i < 3; i++) begin step(); chk_scan(24'h123456, 1'b1); end
      blank = 1'b0;
      step(); chk_scan(24'h123456, 1'b0);

      // out-of-range seconds
      set_time(99, 0, 150);
      step(10);
      chk("oor_bcd", 32'(bcd_out), 32'(model_bcd(99, 0, 150)));
      chk("oor_bcd_const", 32'(bcd_out), 32'h9900FF);
      for (int i = 0; i < 7; i++) begin step(); chk_scan(24'h9900FF, 1'b0); end

      // change during conversion is deferred, never mixed
      set_time(0, 0, 0);
      step(10);
      chk("ovl_zero", 32'(bcd_out), 0);
      set_time(0, 0, 7);
      step(3);
      set_time(0, 0, 42);
      step(6);
      chk("ovl_pre", 32'(bcd_out), 0);
      step();
      chk("ovl_first", 32'(bcd_out), 32'h000007);
      chk("ovl_first_busy", 32'(busy), 0);
      step();
      chk("ovl_restart_busy", 32'(busy), 1);
      step(9);
      chk("ovl_second", 32'(bcd_out), 32'h000042);

      // wrap 23:59:59 -> 00:00:00
      set_time(23, 59, 59);
      step(10);
      chk("wrap_a", 32'(bcd_out), 32'h235959);
      set_time(0, 0, 0);
      step(9);
      chk("wrap_hold", 32'(bcd_out), 32'h235959);
      step();
      chk("wrap_b", 32'(bcd_out), 0);

      // async reset mid-conversion, no partial commit
      set_time(11, 22, 33);
      step(4);
      #2 reset = 1'b1;
      set_time(0, 0, 0);
      #1;
      chk("mid_rst_bcd", 32'(bcd_out), 0);
      chk("mid_rst_busy", 32'(busy), 0);
      chk("mid_rst_an", 32'(an), 32'h01);
      chk("mid_rst_seg", 32'(seg), 32'h3F);
      #2 reset = 1'b0;
      step(12);
      chk("post_rst_bcd", 32'(bcd_out), 0);
      chk("post_rst_busy", 32'(busy), 0);

      // randomized times, some out of range
      ph = 0; pm = 0; ps = 0;
      for (int t = 0; t < 12; t++) begin
         do begin
            h = $urandom_range(0, 110);
            m = $urandom_range(0, 110);
            s = $urandom_range(0, 130);
         end while (h == ph && m == pm && s == ps);
         set_time(h, m, s);
         e = model_bcd(h, m, s);
         step();
         chk("rnd_busy", 32'(busy), 1);
         step(9);
         chk("rnd_bcd", 32'(bcd_out), 32'(e));
         chk("rnd_idle", 32'(busy), 0);
         for (int i = 0; i < 6; i++) begin step(); chk_scan(e, 1'b0); end
         ph = h; pm = m; ps = s;
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
